// File: rtl/rename_map.sv
// Register rename map: speculative/committed RAT, free lists, ready bits and PR values.
// Optional macro RENAME_WB_BYPASS_EN forwards same-cycle writeback data to source lookups.
module rename_map #(
  parameter int W_addr_arf = 5,
  parameter int W_addr_prf = 6,
  parameter int W_data_prf = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  booking,
  input  logic [W_addr_arf-1:0] addr_arf_r1_icdf,
  input  logic [W_addr_arf-1:0] addr_arf_r2_icdf,
  input  logic [W_addr_arf-1:0] addr_arf_r3_icdf,
  output logic [W_addr_prf-1:0] addr_prf_r1_ocdf,
  output logic [W_addr_prf-1:0] addr_prf_r2_ocdf,
  output logic [W_addr_prf-1:0] addr_prf_r3_ocdf,
  output logic [W_addr_prf-1:0] addr_prf_old_ocdf,
  output logic [W_data_prf-1:0] val_prf_r1_ocdf,
  output logic [W_data_prf-1:0] val_prf_r2_ocdf,
  output logic                  valid_prf_r1_ocdf,
  output logic                  valid_prf_r2_ocdf,
  output logic                  stall,
  input  logic                  wb_en,
  input  logic [W_addr_prf-1:0] wb_addr_prf,
  input  logic [W_data_prf-1:0] wb_data,
  input  logic                  ret_en,
  input  logic [W_addr_arf-1:0] ret_addr_arf,
  input  logic [W_addr_prf-1:0] ret_addr_prf_new,
  input  logic [W_addr_prf-1:0] ret_addr_prf_old
);

  localparam int N_ARF = 2 ** W_addr_arf;
  localparam int N_PRF = 2 ** W_addr_prf;
  localparam logic [N_PRF-1:0] RESET_FREE = {{(N_PRF-N_ARF){1'b1}}, {N_ARF{1'b0}}};

  logic [W_addr_prf-1:0] rat_q   [N_ARF];
  logic [W_addr_prf-1:0] rat_d   [N_ARF];
  logic [W_addr_prf-1:0] crat_q  [N_ARF];
  logic [W_addr_prf-1:0] crat_d  [N_ARF];
  logic [W_data_prf-1:0] value_q [N_PRF];
  logic [W_data_prf-1:0] value_d [N_PRF];
  logic [N_PRF-1:0]      free_q, free_d;
  logic [N_PRF-1:0]      cfree_q, cfree_d;
  logic [N_PRF-1:0]      ready_q, ready_d;

  logic                  need;
  logic                  alloc;
  logic [W_addr_prf-1:0] cand;

  // Lowest-index free PR; p0 is never in the free list so 0 doubles as "none".
  always_comb begin
    cand = '0;
    for (int p = N_PRF - 1; p >= 1; p--) begin
      cand = free_q[p] ? W_addr_prf'(p) : cand;
    end
  end

  // Allocation request and stall decision.
  always_comb begin
    need  = booking && (addr_arf_r3_icdf != '0);
    stall = need && (free_q == '0) && !clear;
    alloc = need && (free_q != '0) && !clear;
  end

  // Next state: retire, writeback, then either flush-restore or allocation.
  always_comb begin
    rat_d   = rat_q;
    crat_d  = crat_q;
    value_d = value_q;
    free_d  = free_q;
    cfree_d = cfree_q;
    ready_d = ready_q;
    if (ret_en) begin
      if (ret_addr_arf != '0) begin
        crat_d[ret_addr_arf] = ret_addr_prf_new;
      end else begin
        crat_d[ret_addr_arf] = crat_q[ret_addr_arf];
      end
      if (ret_addr_prf_new != '0) begin
        cfree_d[ret_addr_prf_new] = 1'b0;
      end else begin
        cfree_d[ret_addr_prf_new] = cfree_q[ret_addr_prf_new];
      end
      if (ret_addr_prf_old != '0) begin
        cfree_d[ret_addr_prf_old] = 1'b1;
        free_d[ret_addr_prf_old]  = 1'b1;
      end else begin
        cfree_d[ret_addr_prf_old] = cfree_d[ret_addr_prf_old];
      end
    end else begin
      crat_d = crat_q;
    end
    if (wb_en && (wb_addr_prf != '0)) begin
      value_d[wb_addr_prf] = wb_data;
      ready_d[wb_addr_prf] = 1'b1;
    end else begin
      value_d = value_q;
    end
    // Flush wins over allocation; it sees this cycle's retire through crat_d/cfree_d.
    if (clear) begin
      rat_d   = crat_d;
      free_d  = cfree_d;
      ready_d = '1;
    end else if (alloc) begin
      rat_d[addr_arf_r3_icdf] = cand;
      free_d[cand]            = 1'b0;
      ready_d[cand]           = 1'b0;
    end else begin
      rat_d = rat_q;
    end
  end

  // State registers with synchronous reset to the identity mapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ARF; i++) begin
        rat_q[i]  <= W_addr_prf'(i);
        crat_q[i] <= W_addr_prf'(i);
      end
      for (int p = 0; p < N_PRF; p++) begin
        value_q[p] <= '0;
      end
      free_q  <= RESET_FREE;
      cfree_q <= RESET_FREE;
      ready_q <= '1;
    end else begin
      rat_q   <= rat_d;
      crat_q  <= crat_d;
      value_q <= value_d;
      free_q  <= free_d;
      cfree_q <= cfree_d;
      ready_q <= ready_d;
    end
  end

  // Source lookups read the pre-update RAT; destination outputs only when a rd exists.
  always_comb begin
    addr_prf_r1_ocdf  = rat_q[addr_arf_r1_icdf];
    addr_prf_r2_ocdf  = rat_q[addr_arf_r2_icdf];
    val_prf_r1_ocdf   = value_q[addr_prf_r1_ocdf];
    val_prf_r2_ocdf   = value_q[addr_prf_r2_ocdf];
    valid_prf_r1_ocdf = ready_q[addr_prf_r1_ocdf];
    valid_prf_r2_ocdf = ready_q[addr_prf_r2_ocdf];
`ifdef RENAME_WB_BYPASS_EN
    if (wb_en && (wb_addr_prf != '0) && (wb_addr_prf == addr_prf_r1_ocdf)) begin
      val_prf_r1_ocdf   = wb_data;
      valid_prf_r1_ocdf = 1'b1;
    end else begin
      valid_prf_r1_ocdf = ready_q[addr_prf_r1_ocdf];
    end
    if (wb_en && (wb_addr_prf != '0) && (wb_addr_prf == addr_prf_r2_ocdf)) begin
      val_prf_r2_ocdf   = wb_data;
      valid_prf_r2_ocdf = 1'b1;
    end else begin
      valid_prf_r2_ocdf = ready_q[addr_prf_r2_ocdf];
    end
`endif
    if (need) begin
      addr_prf_r3_ocdf  = cand;
      addr_prf_old_ocdf = rat_q[addr_arf_r3_icdf];
    end else begin
      addr_prf_r3_ocdf  = '0;
      addr_prf_old_ocdf = '0;
    end
  end

endmodule
